// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite hit detector: register field layout,
// coordinate/sprite geometry and helpers that decode a sprite register word.
package sprite_pkg;

    localparam int REG_W       = 32;
    localparam int COORD_W     = 10;
    localparam int ACT_BIT     = 29;
    localparam int X_LSB       = 19;
    localparam int Y_LSB       = 9;
    localparam int SPRITE_SIZE = 20;
    localparam int OFF_W       = $clog2(SPRITE_SIZE);

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } sprite_pos_t;

    // Pull the X and Y origin fields out of a sprite register word.
    function automatic sprite_pos_t get_pos(input logic [REG_W-1:0] word);
        sprite_pos_t p;
        p.x = word[X_LSB +: COORD_W];
        p.y = word[Y_LSB +: COORD_W];
        return p;
    endfunction

    // The "register in use" flag of a sprite register word.
    function automatic logic is_active(input logic [REG_W-1:0] word);
        return word[ACT_BIT];
    endfunction

endpackage

// File: rtl/sprite_hit_detector_if.sv
// Pixel/bank-write bus into the hit detector and its hit/collision results.
interface sprite_hit_detector_if #(
    parameter int NUM_SPRITES = 8
);
    import sprite_pkg::*;

    localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

    logic                   wr_en;
    logic [IDX_W-1:0]       wr_addr;
    logic [REG_W-1:0]       wr_data;
    logic                   pix_valid;
    coord_t                 pix_x;
    coord_t                 pix_y;
    logic                   frame_start;
    logic                   hit_valid;
    logic                   hit;
    logic [IDX_W-1:0]       hit_idx;
    logic [OFF_W-1:0]       off_x;
    logic [OFF_W-1:0]       off_y;
    logic [NUM_SPRITES-1:0] coll_acc;
    logic [NUM_SPRITES-1:0] coll_frame;

    // Pixel source / register writer side
    modport master (
        output wr_en, wr_addr, wr_data, pix_valid, pix_x, pix_y, frame_start,
        input  hit_valid, hit, hit_idx, off_x, off_y, coll_acc, coll_frame
    );

    // Detector side
    modport slave (
        input  wr_en, wr_addr, wr_data, pix_valid, pix_x, pix_y, frame_start,
        output hit_valid, hit, hit_idx, off_x, off_y, coll_acc, coll_frame
    );

endinterface

// File: rtl/sprite_box_cmp.sv
// Combinational box test of one pixel against one sprite register.
// Range ends are formed one bit wider than a coordinate so sprites near the
// right/bottom edge are clipped instead of wrapping around to column/row 0.
module sprite_box_cmp
    import sprite_pkg::*;
(
    input  logic [REG_W-1:0] reg_i,
    input  coord_t           pix_x_i,
    input  coord_t           pix_y_i,
    output logic             hit_o,
    output logic [OFF_W-1:0] off_x_o,
    output logic [OFF_W-1:0] off_y_o
);

    sprite_pos_t      pos;
    logic [COORD_W:0] x_end;
    logic [COORD_W:0] y_end;
    logic             in_x;
    logic             in_y;

    // Half-open [origin, origin+SPRITE_SIZE) test on each axis plus offsets
    always_comb begin
        pos     = get_pos(reg_i);
        x_end   = {1'b0, pos.x} + (COORD_W+1)'(SPRITE_SIZE);
        y_end   = {1'b0, pos.y} + (COORD_W+1)'(SPRITE_SIZE);
        in_x    = (pix_x_i >= pos.x) && ({1'b0, pix_x_i} < x_end);
        in_y    = (pix_y_i >= pos.y) && ({1'b0, pix_y_i} < y_end);
        hit_o   = is_active(reg_i) && in_x && in_y;
        off_x_o = OFF_W'(pix_x_i - pos.x);
        off_y_o = OFF_W'(pix_y_i - pos.y);
    end

endmodule

// File: rtl/sprite_hit_detector.sv
// Sprite register bank with a 2-stage hit pipeline: stage 1 registers the
// per-sprite hit vector and offsets, stage 2 priority-encodes the lowest
// hitting sprite and accumulates per-frame sprite-to-sprite collisions.
module sprite_hit_detector
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    sprite_hit_detector_if.slave bus
);

    localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

    // True when two or more bits of the hit vector are set.
    function automatic logic multi_hit(input logic [NUM_SPRITES-1:0] v);
        return (v & (v - NUM_SPRITES'(1))) != '0;
    endfunction

    logic [REG_W-1:0]       bank_q    [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] hit_vec;
    logic [OFF_W-1:0]       off_x_vec [NUM_SPRITES];
    logic [OFF_W-1:0]       off_y_vec [NUM_SPRITES];

    logic                   vld_p1_q;
    logic                   fs_p1_q;
    logic [NUM_SPRITES-1:0] hit_p1_q;
    logic [OFF_W-1:0]       off_x_p1_q [NUM_SPRITES];
    logic [OFF_W-1:0]       off_y_p1_q [NUM_SPRITES];

    logic                   hit_d;
    logic [IDX_W-1:0]       hit_idx_d;
    logic [OFF_W-1:0]       off_x_d;
    logic [OFF_W-1:0]       off_y_d;
    logic [NUM_SPRITES-1:0] coll_vec_d;
    logic [NUM_SPRITES-1:0] coll_acc_d;
    logic [NUM_SPRITES-1:0] coll_frame_d;

    logic                   vld_p2_q;
    logic                   hit_p2_q;
    logic [IDX_W-1:0]       hit_idx_p2_q;
    logic [OFF_W-1:0]       off_x_p2_q;
    logic [OFF_W-1:0]       off_y_p2_q;
    logic [NUM_SPRITES-1:0] coll_acc_q;
    logic [NUM_SPRITES-1:0] coll_frame_q;

    // Register bank; a pixel in the write cycle still sees the old word
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                bank_q[i] <= '0;
            end
        end else if (bus.wr_en && (32'(bus.wr_addr) < NUM_SPRITES)) begin
            bank_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_cmp
        sprite_box_cmp u_cmp (
            .reg_i   (bank_q[g]),
            .pix_x_i (bus.pix_x),
            .pix_y_i (bus.pix_y),
            .hit_o   (hit_vec[g]),
            .off_x_o (off_x_vec[g]),
            .off_y_o (off_y_vec[g])
        );
    end

    // ---- stage 1: hit vector and frame marker, gated by pixel valid ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1_q <= 1'b0;
            fs_p1_q  <= 1'b0;
            hit_p1_q <= '0;
        end else begin
            vld_p1_q <= bus.pix_valid;
            fs_p1_q  <= bus.pix_valid & bus.frame_start;
            hit_p1_q <= bus.pix_valid ? hit_vec : '0;
        end
    end

    // Stage 1 offsets are pure data and only matter when a hit bit is set
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
            off_x_p1_q[i] <= off_x_vec[i];
            off_y_p1_q[i] <= off_y_vec[i];
        end
    end

    // Lowest-index priority select, collision vector and frame rollover
    always_comb begin
        hit_idx_d = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit_p1_q[i]) begin
                hit_idx_d = IDX_W'(i);
            end
        end
        hit_d      = |hit_p1_q;
        off_x_d    = hit_d ? off_x_p1_q[hit_idx_d] : '0;
        off_y_d    = hit_d ? off_y_p1_q[hit_idx_d] : '0;
        coll_vec_d = multi_hit(hit_p1_q) ? hit_p1_q : '0;
        if (vld_p1_q && fs_p1_q) begin
            // The frame-start pixel opens the new frame
            coll_frame_d = coll_acc_q;
            coll_acc_d   = coll_vec_d;
        end else begin
            coll_frame_d = coll_frame_q;
            coll_acc_d   = coll_acc_q | coll_vec_d;
        end
    end

    // ---- stage 2: output register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p2_q     <= 1'b0;
            hit_p2_q     <= 1'b0;
            hit_idx_p2_q <= '0;
            off_x_p2_q   <= '0;
            off_y_p2_q   <= '0;
            coll_acc_q   <= '0;
            coll_frame_q <= '0;
        end else begin
            vld_p2_q     <= vld_p1_q;
            hit_p2_q     <= hit_d;
            hit_idx_p2_q <= hit_idx_d;
            off_x_p2_q   <= off_x_d;
            off_y_p2_q   <= off_y_d;
            coll_acc_q   <= coll_acc_d;
            coll_frame_q <= coll_frame_d;
        end
    end

    assign bus.hit_valid  = vld_p2_q;
    assign bus.hit        = hit_p2_q;
    assign bus.hit_idx    = hit_idx_p2_q;
    assign bus.off_x      = off_x_p2_q;
    assign bus.off_y      = off_y_p2_q;
    assign bus.coll_acc   = coll_acc_q;
    assign bus.coll_frame = coll_frame_q;

endmodule

// File: tb/tb_sprite_hit_detector.sv
// Directed scoreboard bench for sprite_hit_detector: the stimulus process
// queues hand-computed results, a monitor pops them when hit_valid appears.
module tb_sprite_hit_detector;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        int cyc;
        int hit;
        int idx;
        int ox;
        int oy;
        int ca;
        int cf;
    } exp_t;

    exp_t q[$];
    exp_t me;

    sprite_hit_detector_if #(.NUM_SPRITES(8)) bus ();

    sprite_hit_detector #(.NUM_SPRITES(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic logic [31:0] mk(input bit act, input int x, input int y);
        logic [31:0] w;
        w        = '0;
        w[29]    = act;
        w[28:19] = 10'(x);
        w[18:9]  = 10'(y);
        return w;
    endfunction

    // One cycle of input: write port and pixel port, applied at negedge
    task automatic drive(input bit we, input int wa, input logic [31:0] wd,
                         input bit pv, input int x, input int y, input bit fs);
        @(negedge clk);
        bus.wr_en       = we;
        bus.wr_addr     = 3'(wa);
        bus.wr_data     = wd;
        bus.pix_valid   = pv;
        bus.pix_x       = 10'(x);
        bus.pix_y       = 10'(y);
        bus.frame_start = fs;
    endtask

    task automatic idle();
        drive(1'b0, 0, 32'h0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        drive(1'b1, a, d, 1'b0, 0, 0, 1'b0);
    endtask

    // Pixel whose result must appear two edges after the sampling edge
    task automatic px(input int x, input int y, input bit fs,
                      input int h, input int idx, input int ox, input int oy,
                      input int ca, input int cf);
        exp_t e;
        drive(1'b0, 0, 32'h0, 1'b1, x, y, fs);
        e.cyc = cyc + 2;
        e.hit = h; e.idx = idx; e.ox = ox; e.oy = oy; e.ca = ca; e.cf = cf;
        q.push_back(e);
    endtask

    // Monitor: compare every presented result against the queue head
    always @(posedge clk) begin
        #1;
        if (bus.hit_valid === 1'b1) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid got=1 want=0 (cycle %0d)", cyc);
            end else begin
                me = q.pop_front();
                chk("latency", cyc, me.cyc);
                chk("hit", int'(bus.hit), me.hit);
                chk("hit_idx", int'(bus.hit_idx), me.idx);
                chk("off_x", int'(bus.off_x), me.ox);
                chk("off_y", int'(bus.off_y), me.oy);
                chk("coll_acc", int'(bus.coll_acc), me.ca);
                chk("coll_frame", int'(bus.coll_frame), me.cf);
            end
        end else if (q.size() > 0 && q[0].cyc <= cyc) begin
            total++;
            bad++;
            $display("FAIL missing_valid got=0 want=1 (cycle %0d)", cyc);
            void'(q.pop_front());
        end
    end

    initial begin
        reset           = 1'b1;
        bus.wr_en       = 1'b0;
        bus.wr_addr     = '0;
        bus.wr_data     = '0;
        bus.pix_valid   = 1'b0;
        bus.pix_x       = '0;
        bus.pix_y       = '0;
        bus.frame_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_hit_valid", int'(bus.hit_valid), 0);
        chk("rst_hit", int'(bus.hit), 0);
        chk("rst_hit_idx", int'(bus.hit_idx), 0);
        chk("rst_off_x", int'(bus.off_x), 0);
        chk("rst_off_y", int'(bus.off_y), 0);
        chk("rst_coll_acc", int'(bus.coll_acc), 0);
        chk("rst_coll_frame", int'(bus.coll_frame), 0);
        reset = 1'b0;

        // Single sprite: bank[2] at (100,50)
        wr(2, mk(1'b1, 100, 50));
        px(99, 50, 1'b0,  0, 0, 0, 0,   0, 0);
        px(100, 50, 1'b0, 1, 2, 0, 0,   0, 0);
        px(119, 69, 1'b0, 1, 2, 19, 19, 0, 0);
        px(120, 69, 1'b0, 0, 0, 0, 0,   0, 0);
        idle();

        // Priority: sprites 1 and 5 both cover (200,200)
        wr(1, mk(1'b1, 195, 190));
        wr(5, mk(1'b1, 200, 200));
        px(200, 200, 1'b0, 1, 1, 5, 10, 8'h22, 0);

        // Edge clipping and inactive sprite
        wr(0, mk(1'b1, 1020, 0));
        px(1023, 0, 1'b0, 1, 0, 3, 0, 8'h22, 0);
        px(0, 0, 1'b0,    0, 0, 0, 0, 8'h22, 0);
        wr(0, mk(1'b0, 1020, 0));
        px(1021, 5, 1'b0, 0, 0, 0, 0, 8'h22, 0);

        // Frame rollover
        px(0, 0, 1'b1, 0, 0, 0, 0, 0, 8'h22);
        wr(3, mk(1'b1, 300, 300));
        wr(4, mk(1'b1, 310, 305));
        px(315, 310, 1'b0, 1, 3, 15, 10, 8'h18, 8'h22);
        px(0, 0, 1'b1,     0, 0, 0, 0,   0, 8'h18);
        px(500, 500, 1'b0, 0, 0, 0, 0,   0, 8'h18);
        px(0, 0, 1'b1,     0, 0, 0, 0,   0, 0);

        // frame_start without pix_valid must not roll the frame
        px(315, 310, 1'b0, 1, 3, 15, 10, 8'h18, 0);
        drive(1'b0, 0, 32'h0, 1'b0, 0, 0, 1'b1);
        px(0, 0, 1'b0, 0, 0, 0, 0, 8'h18, 0);

        // Write and pixel in the same cycle: pixel sees the old word
        drive(1'b1, 7, mk(1'b1, 5, 5), 1'b1, 10, 10, 1'b0);
        begin
            exp_t e;
            e.cyc = cyc + 2;
            e.hit = 0; e.idx = 0; e.ox = 0; e.oy = 0; e.ca = 8'h18; e.cf = 0;
            q.push_back(e);
        end
        px(10, 10, 1'b0, 1, 7, 5, 5, 8'h18, 0);
        idle();
        idle();
        idle();

        // Reset with pixels in flight
        drive(1'b0, 0, 32'h0, 1'b1, 10, 10, 1'b0);
        drive(1'b0, 0, 32'h0, 1'b1, 315, 310, 1'b0);
        reset = 1'b1;
        idle();
        reset = 1'b0;
        idle();
        chk("post_rst_hit_valid", int'(bus.hit_valid), 0);
        chk("post_rst_coll_acc", int'(bus.coll_acc), 0);
        chk("post_rst_coll_frame", int'(bus.coll_frame), 0);
        px(10, 10, 1'b0,   0, 0, 0, 0, 0, 0);
        px(315, 310, 1'b0, 0, 0, 0, 0, 0, 0);
        px(100, 50, 1'b0,  0, 0, 0, 0, 0, 0);
        repeat (5) idle();
        chk("queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sprite_hit_detector.md
Name: sprite_hit_detector

Overview:
- Parametrised successor to the single-register sprite box comparator. Holds a bank of NUM_SPRITES sprite registers and tests each incoming pixel against all of them in a 2-stage pipeline.
- Reports the highest-priority hit, meaning the lowest register index, together with the pixel's offset inside that sprite.
- Accumulates per-frame sprite-to-sprite collision flags.
- Sits between the VGA pixel counter and the sprite memory address generator.

Parameters:
- NUM_SPRITES, 8, number of sprite registers in the bank.
- REG_W, 32, width of one sprite register.
- COORD_W, 10, width of each pixel coordinate.
- ACT_BIT, 29, bit position of the "register in use" flag.
- X_LSB, 19, LSB of the sprite X field; the field is COORD_W bits wide.
- Y_LSB, 9, LSB of the sprite Y field; the field is COORD_W bits wide.
- SPRITE_SIZE, 20, sprite edge length in pixels. The sprite is square.
- IDX_W, $clog2(NUM_SPRITES), width of the sprite index.
- OFF_W, $clog2(SPRITE_SIZE), width of the in-sprite offset.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous, active-high.
- wr_en, in, 1, write strobe for the register bank.
- wr_addr, in, IDX_W, index of the register to write.
- wr_data, in, REG_W, value to write.
- pix_valid, in, 1, the pixel coordinate is valid this cycle.
- pix_x, in, COORD_W, current pixel column.
- pix_y, in, COORD_W, current pixel row.
- frame_start, in, 1, first pixel of a new frame. Qualified by pix_valid.
- hit_valid, out, 1, outputs correspond to a pixel accepted 2 cycles earlier.
- hit, out, 1, at least one active sprite covers the pixel.
- hit_idx, out, IDX_W, lowest-index sprite covering the pixel.
- off_x, out, OFF_W, pix_x minus the X field of sprite hit_idx.
- off_y, out, OFF_W, pix_y minus the Y field of sprite hit_idx.
- coll_acc, out, NUM_SPRITES, live collision flags for the current frame.
- coll_frame, out, NUM_SPRITES, collision flags of the last completed frame.

Behaviour:
- Reset:
  - Every bank register is cleared, so all sprites are inactive.
  - All pipeline valid bits are cleared.
  - hit_valid, hit, hit_idx, off_x, off_y, coll_acc and coll_frame all reset to 0.
- Register bank:
  - When wr_en is high, bank[wr_addr] takes wr_data at the clock edge.
  - A pixel sampled in the same cycle as a write sees the old value. The new value is visible from the next cycle.
  - wr_addr >= NUM_SPRITES is ignored.
- Hit test, per sprite i:
  - hit_i = bank[i][ACT_BIT] && X <= pix_x < X+SPRITE_SIZE && Y <= pix_y < Y+SPRITE_SIZE.
  - The ranges are half-open, giving exactly SPRITE_SIZE pixels per axis.
  - Sums are computed in COORD_W+1 bits, so a sprite near the coordinate maximum does not wrap. A sprite at X = 1020 covers 1020..1023 only.
- Stage 1 (cycle t+1):
  - Registers the hit vector for all sprites.
  - Registers each sprite's offsets, truncated to OFF_W bits.
  - Registers frame_start and pix_valid.
- Stage 2 (cycle t+2), output register:
  - A priority encoder selects the lowest set index.
  - hit = OR of the hit vector.
  - With no hit: hit_idx, off_x and off_y are 0.
  - hit_valid = delayed pix_valid. When pix_valid is low, the hit vector is forced to 0.
- Latency and throughput:
  - Fixed latency of 2 cycles.
  - One pixel per cycle.
  - No backpressure.
- Collision accumulation, applied at stage 2:
  - A pixel with two or more hit bits set ORs its hit vector into coll_acc.
- Frame boundary:
  - frame_start travels in the pipeline with its pixel.
  - At stage 2 the flagged pixel causes coll_frame <= coll_acc, excluding that pixel.
  - At the same time coll_acc <= that pixel's collision vector, or 0 if it has no collision.
  - The first pixel of a frame therefore belongs to the new frame.
- A frame_start with pix_valid low is ignored.
- Reset asserted mid-frame discards pixels in flight. No stale hit_valid appears after reset deasserts.

Decomposition:
- Package sprite_pkg holds the shared definitions:
  - field positions: ACT_BIT, X_LSB, Y_LSB;
  - COORD_W and SPRITE_SIZE;
  - a function that extracts the X and Y fields from a register word.
- Sub-module sprite_box_cmp is instantiated NUM_SPRITES times. It is purely combinational and produces the per-sprite hit bit plus off_x and off_y.
- The top level contains the bank, the pipeline registers, the priority encoder and the collision logic.

Test Plan:
- Single sprite:
  - Stimulus: write bank[2] = active, X=100, Y=50. Scan pixels (99,50), (100,50), (119,69), (120,69).
  - Required: hit = 0, 1, 1, 0.
  - On the hits: hit_idx = 2, with offsets (0,0) and (19,19).
  - Each result appears exactly 2 cycles after its pixel.
- Priority:
  - Stimulus: sprites 1 and 5 both cover (200,200). Sprite 1 at (195,190), sprite 5 at (200,200).
  - Required: hit_idx = 1, off = (5,10).
  - Also required: coll_acc = 8'b0010_0010.
- Inactive and edge:
  - Stimulus A: sprite 0 at (1020,0) with ACT = 1. Query (1023,0) and (0,0).
  - Required A: hit = 1, then 0, showing no wrap.
  - Stimulus B: the same sprite with ACT = 0, queried at a covered pixel.
  - Required B: hit = 0.
- Frame rollover:
  - Stimulus: a collision on sprites 3 and 4 in frame N, then pix_valid with frame_start and no collision.
  - Required: coll_frame = 8'h18 and coll_acc = 0, both in the same cycle.
  - Stimulus: a second frame with no collisions, then another frame_start.
  - Required: coll_frame = 0.
- Write/read same cycle:
  - Stimulus: activate sprite 7 covering (10,10) in the same cycle that pixel (10,10) is presented.
  - Required: hit = 0 for that pixel.
  - Required: the next pixel (10,10) gives hit = 1, hit_idx = 7.
- Reset mid-stream:
  - Stimulus: assert reset with 2 valid pixels in flight.
  - Required: the cycle after reset shows hit_valid = 0, coll_acc = 0, coll_frame = 0.
  - Required: all sprites are inactive afterwards.
